// File: rtl/mux32_rr_arbiter.sv
// Round-robin arbiter and select sequencer for a 32:1 mux tree.
// Grants one requester at a time for up to hold_len+1 cycles, rotating priority after each grant.
module mux32_rr_arbiter #(
  parameter int unsigned HoldW = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [31:0]      req_i,
  input  logic [HoldW-1:0] hold_len_i,
  input  logic             release_i,
  output logic [4:0]       sel_o,
  output logic [31:0]      gnt_o,
  output logic             busy_o,
  output logic             new_gnt_o
);

  typedef enum logic [0:0] {StIdle, StGrant} state_e;

  state_e           state_q;
  logic [4:0]       ptr_q;
  logic [HoldW-1:0] cnt_q;
  logic [4:0]       sel_q;
  logic [31:0]      gnt_q;
  logic             busy_q;
  logic             new_gnt_q;

  logic [4:0] arb_ptr;
  logic [4:0] arb_idx;
  logic [4:0] scan_idx;
  logic       arb_found;
  logic       end_evt;

  // On a grant end the pointer moves past the current grantee within the same edge,
  // so the re-arbitration scans from sel+1 rather than the stored pointer.
  always_comb begin
    arb_ptr   = (state_q == StGrant) ? sel_q + 5'd1 : ptr_q;
    arb_idx   = '0;
    arb_found = 1'b0;
    scan_idx  = '0;
    for (int k = 0; k < 32; k++) begin
      scan_idx = arb_ptr + 5'(k);
      if (!arb_found && req_i[scan_idx]) begin
        arb_found = 1'b1;
        arb_idx   = scan_idx;
      end
    end
  end

  assign end_evt = (cnt_q == '0) || release_i || !req_i[sel_q];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= StIdle;
      ptr_q     <= '0;
      cnt_q     <= '0;
      sel_q     <= '0;
      gnt_q     <= '0;
      busy_q    <= 1'b0;
      new_gnt_q <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (arb_found) begin
            state_q   <= StGrant;
            sel_q     <= arb_idx;
            gnt_q     <= 32'd1 << arb_idx;
            cnt_q     <= hold_len_i;
            busy_q    <= 1'b1;
            new_gnt_q <= 1'b1;
          end
        end
        StGrant: begin
          if (end_evt) begin
            ptr_q <= sel_q + 5'd1;
            if (arb_found) begin
              sel_q     <= arb_idx;
              gnt_q     <= 32'd1 << arb_idx;
              cnt_q     <= hold_len_i;
              new_gnt_q <= 1'b1;
            end else begin
              state_q   <= StIdle;
              sel_q     <= '0;
              gnt_q     <= '0;
              cnt_q     <= '0;
              busy_q    <= 1'b0;
              new_gnt_q <= 1'b0;
            end
          end else begin
            cnt_q     <= cnt_q - 1'b1;
            new_gnt_q <= 1'b0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign sel_o     = sel_q;
  assign gnt_o     = gnt_q;
  assign busy_o    = busy_q;
  assign new_gnt_o = new_gnt_q;

endmodule

// File: tb/tb_mux32_rr_arbiter.sv
// Self-checking bench for mux32_rr_arbiter: grant-level behavioural model compared every
// cycle, plus hand-computed literal expectations for the directed scenarios.
module tb_mux32_rr_arbiter;

  logic        clk;
  logic        rst_n;
  logic [31:0] req;
  logic [3:0]  hold_len;
  logic        rel;
  logic [4:0]  sel;
  logic [31:0] gnt;
  logic        busy;
  logic        new_gnt;

  int n_checks = 0;
  int n_pass   = 0;

  mux32_rr_arbiter #(.HoldW(4)) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .req_i      (req),
    .hold_len_i (hold_len),
    .release_i  (rel),
    .sel_o      (sel),
    .gnt_o      (gnt),
    .busy_o     (busy),
    .new_gnt_o  (new_gnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: a grant is (who, how many cycles allowed, how many cycles used).
  int m_busy, m_sel, m_used, m_len, m_ptr, m_new;

  function automatic int pick(input int p, input logic [31:0] r);
    for (int k = 0; k < 32; k++) begin
      if (r[(p + k) % 32]) return (p + k) % 32;
    end
    return -1;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    int c;
    bit fin;
    if (!rst_n) begin
      m_busy = 0; m_sel = 0; m_used = 0; m_len = 0; m_ptr = 0; m_new = 0;
    end else if (m_busy == 0) begin
      c = pick(m_ptr, req);
      if (c >= 0) begin
        m_busy = 1; m_sel = c; m_used = 0; m_len = hold_len + 1; m_new = 1;
      end
    end else begin
      m_used = m_used + 1;
      fin = (m_used >= m_len) || rel || !req[m_sel];
      if (fin) begin
        m_ptr = (m_sel + 1) % 32;
        c = pick(m_ptr, req);
        if (c >= 0) begin
          m_sel = c; m_used = 0; m_len = hold_len + 1; m_new = 1;
        end else begin
          m_busy = 0; m_sel = 0; m_new = 0;
        end
      end else begin
        m_new = 0;
      end
    end
  end

  always @(negedge clk) begin
    logic [31:0] eg;
    eg = (m_busy != 0) ? (32'd1 << m_sel) : 32'd0;
    n_checks++;
    if (sel === 5'(m_sel) && gnt === eg && busy === (m_busy != 0) && new_gnt === (m_new != 0))
      n_pass++;
    else
      $display("FAIL model t=%0t: got sel=%0d gnt=%h busy=%b new=%b, want sel=%0d gnt=%h busy=%0d new=%0d",
               $time, sel, gnt, busy, new_gnt, m_sel, eg, m_busy, m_new);
  end

  task automatic lit(input string name, input logic [4:0] es, input logic [31:0] eg,
                     input logic eb, input logic en);
    n_checks++;
    if (sel === es && gnt === eg && busy === eb && new_gnt === en)
      n_pass++;
    else
      $display("FAIL %s: got sel=%0d gnt=%h busy=%b new=%b, want sel=%0d gnt=%h busy=%b new=%b",
               name, sel, gnt, busy, new_gnt, es, eg, eb, en);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req   = '0;
    rel   = 1'b0;
    cyc(2);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; req = 32'hFFFF_FFFF; hold_len = 4'd3; rel = 1'b0;
    cyc(3);
    lit("reset_hold", 5'd0, 32'h0, 1'b0, 1'b0);
    req = '0;
    rst_n = 1'b1;
    cyc(3);
    lit("idle_after_reset", 5'd0, 32'h0, 1'b0, 1'b0);

    // Single requester, 4-cycle grants; hold_len change mid-grant only affects the next load.
    hold_len = 4'd3; req = 32'h0000_0020;
    cyc(1);
    lit("single_first", 5'd5, 32'h20, 1'b1, 1'b1);
    cyc(1);
    lit("single_second", 5'd5, 32'h20, 1'b1, 1'b0);
    hold_len = 4'd7;
    cyc(3);
    lit("single_regrant", 5'd5, 32'h20, 1'b1, 1'b1);
    req = '0;
    cyc(1);
    lit("single_drop_idle", 5'd0, 32'h0, 1'b0, 1'b0);

    // Round-robin with wrap, one cycle per grant.
    do_reset();
    hold_len = 4'd0; req = 32'h8000_0003;
    cyc(1); lit("rr_0", 5'd0, 32'h0000_0001, 1'b1, 1'b1);
    cyc(1); lit("rr_1", 5'd1, 32'h0000_0002, 1'b1, 1'b1);
    cyc(1); lit("rr_31", 5'd31, 32'h8000_0000, 1'b1, 1'b1);
    cyc(1); lit("rr_wrap0", 5'd0, 32'h0000_0001, 1'b1, 1'b1);
    cyc(3);
    req = '0;
    cyc(2);

    // Early release in the third grant cycle.
    do_reset();
    hold_len = 4'd15; req = 32'h0000_0300;
    cyc(1); lit("rel_first", 5'd8, 32'h100, 1'b1, 1'b1);
    cyc(2); lit("rel_third", 5'd8, 32'h100, 1'b1, 1'b0);
    rel = 1'b1;
    cyc(1); lit("rel_switch", 5'd9, 32'h200, 1'b1, 1'b1);
    rel = 1'b0;
    cyc(2);
    req = '0;
    cyc(2);

    // cnt expiry, release and dropped request on the same edge.
    do_reset();
    hold_len = 4'd1; req = 32'h0000_0300;
    cyc(1); lit("sim_first", 5'd8, 32'h100, 1'b1, 1'b1);
    cyc(1);
    rel = 1'b1; req = 32'h0000_0200;
    cyc(1); lit("sim_switch", 5'd9, 32'h200, 1'b1, 1'b1);
    rel = 1'b0;
    cyc(1); lit("sim_hold", 5'd9, 32'h200, 1'b1, 1'b0);
    cyc(1); lit("sim_regrant9", 5'd9, 32'h200, 1'b1, 1'b1);
    req = '0;
    cyc(2);

    // Async reset between edges during a grant to 17.
    do_reset();
    hold_len = 4'd15; req = 32'h0002_0000;
    cyc(2); lit("async_pre", 5'd17, 32'h0002_0000, 1'b1, 1'b0);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    lit("async_now", 5'd0, 32'h0, 1'b0, 1'b0);
    req = 32'h0002_0001;
    cyc(1);
    rst_n = 1'b1;
    cyc(1); lit("async_after", 5'd0, 32'h0000_0001, 1'b1, 1'b1);
    req = '0;
    cyc(2);

    // Short mixed phase covered by the model only.
    for (int i = 0; i < 80; i++) begin
      case ($urandom_range(0, 3))
        0: req = $urandom & $urandom;
        1: req = 32'd1 << $urandom_range(0, 31);
        2: req = $urandom;
        default: req = '0;
      endcase
      hold_len = 4'($urandom_range(0, 15));
      rel      = ($urandom_range(0, 4) == 0);
      cyc(1);
    end
    rel = 1'b0; req = '0;
    cyc(3);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mux32_rr_arbiter.md
# mux32_rr_arbiter

Round-robin arbiter and select sequencer for the 32:1 mux tree (`MUXTree32`). It shares the single mux output among 32 requesters by granting one line at a time and driving the 5-bit select `s` of the tree. Each grant lasts a bounded number of cycles. The block sits directly in front of the mux tree; consumers of the mux output qualify it with `busy` and `gnt`.

## Interface
- `HOLD_W`, default 4: width of the grant-hold length field. The maximum grant is 2^HOLD_W cycles.
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `req`  in  32: request vector; bit i requests mux input i; level-sensitive.
- `hold_len`  in  HOLD_W: grant lasts up to hold_len+1 cycles; sampled only when a grant is loaded.
- `release`  in  1: grantee ends its grant early; sampled while `busy`=1.
- `sel`  out  5: select to mux tree `s`; index of current grantee.
- `gnt`  out  32: one-hot grant vector, equal to 1<<sel when busy, else 0.
- `busy`  out  1: a grant is active; the mux output is valid for requester `sel`.
- `new_gnt`  out  1: one-cycle pulse in the first cycle of every grant.

## Operation
- Internal state:
  - `state` ∈ {IDLE, GRANT}.
  - `ptr[4:0]`: highest-priority index for the next arbitration.
  - `cnt[HOLD_W-1:0]`: remaining hold cycles.
- Arbitration function: choose the first i with req[i]=1, scanning ptr, ptr+1, …, 31, 0, …, ptr-1 (mod 32). If req=0, nothing is chosen.
- IDLE:
  - If req≠0 at an edge: load sel=chosen index, gnt=1<<sel, cnt=hold_len, busy=1, new_gnt=1, go to GRANT.
  - Otherwise remain in IDLE with all outputs 0.
- GRANT, end condition at an edge: cnt==0 OR release==1 OR req[sel]==0. Any combination of these is a single end event.
- GRANT, no end: cnt decrements by 1. sel, gnt and busy hold; new_gnt=0.
- GRANT, end:
  - ptr ← sel+1 (5-bit wrap, 31→0).
  - Arbitrate again in the same edge, using the updated ptr and the current req. The current grantee therefore has lowest priority.
  - If a requester is chosen: load a new grant (sel, gnt, cnt=hold_len, new_gnt=1) and stay in GRANT. There is no idle bubble.
  - If req=0: go to IDLE with sel=0, gnt=0, busy=0.
- A sole requester holding req high is re-granted back-to-back with new_gnt=1 each time.
- Changes to hold_len during a grant have no effect until the next grant load.
- `release` in IDLE is ignored.
- gnt is always one-hot or zero. gnt≠0 if and only if busy=1.

## Timing
- Reset (asynchronous, immediate, including mid-grant): state=IDLE, ptr=0, cnt=0, sel=0, gnt=0, busy=0, new_gnt=0. After rst_n rises, the first arbitration uses ptr=0.
- All outputs are registered; no combinational path from inputs to outputs.
- Request-to-grant latency: req sampled at edge k gives gnt/busy high after edge k.
- Grant duration: hold_len+1 cycles without early end; minimum 1 cycle.
- Early end: release or req[sel] low sampled at edge k ends the grant at edge k.
- Grant switch: the old grant ends and the new grant starts on the same edge. new_gnt is high for exactly the first cycle of each grant.
- Priority rotation: after a grant to index i, the next arbitration starts at (i+1) mod 32.

## Test plan
- Reset/idle: hold rst_n=0, req=32'hFFFF_FFFF → sel=0, gnt=0, busy=0 throughout. Release rst_n with req=0 → outputs stay 0.
- Single grant length: hold_len=3, pulse req=32'h0000_0020 held high → gnt=32'h20, sel=5 for 4 cycles, then re-grant to 5 with new_gnt=1. Drop req → IDLE the edge after req is sampled low.
- Round-robin with wrap: hold_len=0, req=32'h8000_0003 held → grant order 0, 1, 31, 0, 1, … with one cycle each and no bubbles.
- Early release: hold_len=15, req=32'h0000_0300, assert release in the 3rd grant cycle → grant to 8 ends after 3 cycles and switches to 9 on the same edge.
- Simultaneous end events: cnt==0, release=1 and req[sel]=0 on the same edge → exactly one switch; ptr advances once; no double new_gnt.
- Async reset mid-grant: assert rst_n=0 between edges during a grant to sel=17 → all outputs 0 immediately. After reset, req=32'h0002_0001 grants index 0 first.
